// File: rtl/commit_monitor.sv
// Retire-side commit monitor: registers up to NCOMMIT retire lanes onto commit
// channels, keeps cycle/instruction counters, and halts reporting after a trap.
module commit_monitor #(
   parameter int               NCOMMIT     = 2,
   parameter int               XLEN        = 64,
   parameter logic [XLEN-1:0]  PC_START    = XLEN'(64'h8000_0000),
   parameter logic [6:0]       TRAP_OPCODE = 7'h6b
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NCOMMIT-1:0]      in_valid,
   input  logic [NCOMMIT*XLEN-1:0] in_pc,
   input  logic [NCOMMIT*32-1:0]   in_inst,
   input  logic [NCOMMIT-1:0]      in_wen,
   input  logic [NCOMMIT*5-1:0]    in_wdest,
   input  logic [NCOMMIT*XLEN-1:0] in_wdata,
   input  logic [NCOMMIT-1:0]      in_skip,
   input  logic [7:0]              in_trap_code,
   output logic [NCOMMIT-1:0]      cmt_valid,
   output logic [NCOMMIT*XLEN-1:0] cmt_pc,
   output logic [NCOMMIT*32-1:0]   cmt_inst,
   output logic [NCOMMIT-1:0]      cmt_wen,
   output logic [NCOMMIT*8-1:0]    cmt_wdest,
   output logic [NCOMMIT*XLEN-1:0] cmt_wdata,
   output logic [NCOMMIT-1:0]      cmt_skip,
   output logic [63:0]             cycle_cnt,
   output logic [63:0]             instr_cnt,
   output logic                    trap_valid,
   output logic [7:0]              trap_code,
   output logic [XLEN-1:0]         trap_pc,
   output logic                    halted,
   output logic                    proto_err
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_TRAP   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t              state_r;
   logic                first_done_r;
   logic [NCOMMIT-1:0]  accept_s;
   logic                trap_hit_s;
   logic                noncontig_s;
   logic [XLEN-1:0]     trap_pc_s;
   logic [63:0]         accept_cnt_s;

   function automatic logic [63:0] popcount(input logic [NCOMMIT-1:0] vec);
      logic [63:0] cnt;
      cnt = 64'd0;
      for (int k = 0; k < NCOMMIT; k++) begin
         cnt = cnt + {63'd0, vec[k]};
      end
      return cnt;
   endfunction

   // Lane acceptance: contiguous valid prefix, cut after the lowest trap lane
   always_comb begin
      logic open_v;
      logic contig_v;
      accept_s    = '0;
      trap_hit_s  = 1'b0;
      trap_pc_s   = '0;
      noncontig_s = 1'b0;
      open_v      = (state_r == ST_RUN);
      contig_v    = 1'b1;
      for (int i = 0; i < NCOMMIT; i++) begin
         contig_v = contig_v & in_valid[i];
         if (in_valid[i] && !contig_v) begin
            noncontig_s = 1'b1;
         end else begin
            noncontig_s = noncontig_s;
         end
         if (open_v && in_valid[i]) begin
            accept_s[i] = 1'b1;
            if (in_inst[i*32 +: 7] == TRAP_OPCODE) begin
               trap_hit_s = 1'b1;
               trap_pc_s  = in_pc[i*XLEN +: XLEN];
               open_v     = 1'b0;
            end else begin
               open_v = open_v;
            end
         end else begin
            open_v = 1'b0;
         end
      end
      accept_cnt_s = popcount(accept_s);
   end

   // Commit channels, counters, trap latch and RUN/TRAP/HALTED state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_RUN;
         first_done_r <= 1'b0;
         cmt_valid    <= '0;
         cmt_pc       <= '0;
         cmt_inst     <= '0;
         cmt_wen      <= '0;
         cmt_wdest    <= '0;
         cmt_wdata    <= '0;
         cmt_skip     <= '0;
         cycle_cnt    <= 64'd0;
         instr_cnt    <= 64'd0;
         trap_valid   <= 1'b0;
         trap_code    <= 8'd0;
         trap_pc      <= '0;
         halted       <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         cmt_valid  <= accept_s;
         trap_valid <= trap_hit_s;
         for (int i = 0; i < NCOMMIT; i++) begin
            if (accept_s[i]) begin
               cmt_pc[i*XLEN +: XLEN]    <= in_pc[i*XLEN +: XLEN];
               cmt_inst[i*32 +: 32]      <= in_inst[i*32 +: 32];
               cmt_wdata[i*XLEN +: XLEN] <= in_wdata[i*XLEN +: XLEN];
               cmt_wdest[i*8 +: 8]       <= {3'd0, in_wdest[i*5 +: 5]};
               cmt_wen[i]  <= in_wen[i] & (in_wdest[i*5 +: 5] != 5'd0);
               cmt_skip[i] <= in_skip[i] |
                              ((in_pc[i*XLEN +: XLEN] == PC_START) && !first_done_r);
            end else begin
               cmt_pc[i*XLEN +: XLEN]    <= '0;
               cmt_inst[i*32 +: 32]      <= 32'd0;
               cmt_wdata[i*XLEN +: XLEN] <= '0;
               cmt_wdest[i*8 +: 8]       <= 8'd0;
               cmt_wen[i]                <= 1'b0;
               cmt_skip[i]               <= 1'b0;
            end
         end
         case (state_r)
            ST_RUN: begin
               cycle_cnt <= cycle_cnt + 64'd1;
               instr_cnt <= instr_cnt + accept_cnt_s;
               if (|accept_s) begin
                  first_done_r <= 1'b1;
               end else begin
                  first_done_r <= first_done_r;
               end
               if (noncontig_s) begin
                  proto_err <= 1'b1;
               end else begin
                  proto_err <= proto_err;
               end
               if (trap_hit_s) begin
                  state_r   <= ST_TRAP;
                  halted    <= 1'b1;
                  trap_pc   <= trap_pc_s;
                  trap_code <= in_trap_code;
               end else begin
                  state_r <= ST_RUN;
                  halted  <= 1'b0;
               end
            end
            ST_TRAP: begin
               state_r <= ST_HALTED;
               halted  <= 1'b1;
            end
            ST_HALTED: begin
               state_r <= ST_HALTED;
               halted  <= 1'b1;
            end
            // An undefined encoding is treated as a halt so reporting stays frozen
            default: begin
               state_r <= ST_HALTED;
               halted  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Parametrised retire-side commit monitor between the core's writeback stage and the difftest commit, trap and counter interfaces. It takes up to NCOMMIT retire events per cycle and registers them onto per-lane commit channels. It keeps the 64-bit cycle and instruction counters, generates skip flags, and detects the trap instruction. After a trap it runs a RUN/TRAP/HALTED state machine and freezes all reporting.

## Interface
- NCOMMIT, 2, retire lanes per cycle (1..4)
- XLEN, 64, data/pc width
- PC_START, 64'h8000_0000, reset pc; first committed instruction at this pc is skipped
- TRAP_OPCODE, 7'h6b, inst[6:0] value identifying the trap instruction

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  NCOMMIT  lane retire valid, must be contiguous from lane 0
- in_pc  in  NCOMMIT*XLEN  retired pc per lane
- in_inst  in  NCOMMIT*32  retired instruction per lane
- in_wen  in  NCOMMIT  rd write enable per lane
- in_wdest  in  NCOMMIT*5  rd index per lane
- in_wdata  in  NCOMMIT*XLEN  rd write data per lane
- in_skip  in  NCOMMIT  core-requested skip (MMIO access) per lane
- in_trap_code  in  8  a0[7:0] as seen by the trap instruction
- cmt_valid  out  NCOMMIT  registered commit valid per lane
- cmt_pc, cmt_inst, cmt_wen, cmt_wdata  out  per-lane widths as inputs  registered commit fields
- cmt_wdest  out  NCOMMIT*8  {3'd0, wdest}
- cmt_skip  out  NCOMMIT  registered skip
- cycle_cnt  out  64  cycles spent in RUN
- instr_cnt  out  64  committed instructions
- trap_valid  out  1  one-cycle trap pulse
- trap_code  out  8  latched trap code
- trap_pc  out  XLEN  latched trap pc
- halted  out  1  high in TRAP and HALTED
- proto_err  out  1  sticky: non-contiguous in_valid seen

## Operation
- Lane i is accepted when in_valid[0..i] are all 1, there is no trap in a lower lane, and the state is RUN.
- Non-contiguous valid pattern (e.g. 2'b10) sets proto_err. Lanes above the first 0 are dropped and not counted.
- cmt_wen = in_wen & (in_wdest != 0), forced 0 for wdest 0.
- cmt_skip = in_skip | (pc == PC_START && !first_done). first_done sets on the first accepted lane and clears only on reset.
- Trap: the lowest accepted lane with inst[6:0] == TRAP_OPCODE. That lane commits normally. Higher lanes in the same cycle are suppressed.
- On trap, latch trap_pc and trap_code and go to TRAP.
- instr_cnt += popcount(accepted lanes), an adder of width 64 that wraps modulo 2^64.
- cycle_cnt += 1 on every RUN cycle, including the cycle the trap retires. It wraps modulo 2^64.

State machine:
- RUN→TRAP on an accepted trap lane.
- TRAP→HALTED unconditionally after 1 cycle.
- HALTED holds until reset.
- In TRAP and HALTED, inputs are ignored, cmt_valid = 0, and the counters freeze.

## Timing
- All outputs are registered. Latency is 1 cycle from retire inputs to cmt_* and counters.
- trap_valid is high for exactly the cycle in which cmt_valid shows the trap instruction.
- halted rises with trap_valid and stays high.
- Reset values: all outputs 0 (cmt_*, counters, trap_*, halted, proto_err), state RUN, first_done 0.
- Reset mid-operation, in any state including HALTED, has the same result next cycle.
- Reset has priority over simultaneous retire input.
- A trap and a proto_err pattern in the same cycle are both honoured.
- The trap lane is evaluated only among contiguous accepted lanes.

## Test plan
- Reset, then lane0 valid pc=0x80000000 addi x1: next cycle cmt_valid=01, cmt_skip[0]=1, instr_cnt=1, cycle_cnt=1. A second instruction at the same pc (loop) has skip=0.
- NCOMMIT=2, both lanes valid for 3 cycles with in_wen=1, wdest=0 on lane1: instr_cnt=6, cmt_wen[1]=0, cmt_wdest[1]=8'd0.
- in_valid=2'b10: cmt_valid=00, instr_cnt unchanged, proto_err=1 and stays 1 until reset.
- Lane0 trap (inst=0x0000006b, pc=0x80000040, code=0x00) with lane1 valid: cmt_valid=01, trap_valid=1 for one cycle, trap_pc=0x80000040, halted=1. Further inputs give cmt_valid=0, and the counters freeze.
- Lane1 trap with lane0 normal: both lanes commit, instr_cnt +2, trap_pc = lane1 pc.
- Assert reset while HALTED: the next cycle shows all outputs 0, RUN state, and the first instruction at PC_START is skipped again.
